// File: rtl/verinject_sched_pkg.sv
// rtl/verinject_sched_pkg.sv - shared types and constants for the injection scheduler
package verinject_sched_pkg;

  localparam logic [31:0] VERINJECT_IDLE_STATE = 32'hFFFF_FFFF;
  localparam int          ENTRY_W              = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } sched_state_e;

  // One schedule entry: target cycle in the upper word, bit index in the lower.
  typedef struct packed {
    logic [31:0] cycle;
    logic [31:0] index;
  } sched_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/verinject_sched_fifo.sv
// rtl/verinject_sched_fifo.sv - DEPTH x 64 schedule FIFO with flush
module verinject_sched_fifo
  import verinject_sched_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  sched_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output sched_entry_t head,
  output logic         empty,
  output logic         full
);

  // Extra MSB on each pointer distinguishes full from empty when the low bits match.
  logic [DEPTH_LOG2:0] wptr_q;
  logic [DEPTH_LOG2:0] rptr_q;
  sched_entry_t        mem_q [DEPTH];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                 (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign head  = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  // Storage array is not reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (push && !full && !flush) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= push_data;
    end
  end

  // Pointer update; flush empties the FIFO and wins over push and pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) begin
        wptr_q <= wptr_q + (DEPTH_LOG2+1)'(1);
      end
      if (pop && !empty) begin
        rptr_q <= rptr_q + (DEPTH_LOG2+1)'(1);
      end
    end
  end

endmodule

// File: rtl/verinject_injection_scheduler.sv
// rtl/verinject_injection_scheduler.sv - replays a (cycle, bit-index) list onto the injector bus
module verinject_injection_scheduler
  import verinject_sched_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [31:0] push_cycle,
  input  logic [31:0] push_index,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] verinject__injector_state,
  output logic [31:0] cycle_count,
  output logic        busy,
  output logic        done,
  output logic [15:0] fired_count,
  output logic [15:0] late_count
);

  sched_state_e state_q;
  logic [31:0]  cycle_q;
  logic [31:0]  inj_q;
  logic [15:0]  fired_q;
  logic [15:0]  late_q;

  sched_entry_t push_entry;
  sched_entry_t head;
  logic         fifo_empty;
  logic         fifo_full;
  logic         push_hs;
  logic         push_wr;
  logic         fire;
  logic         fire_late;
  logic [31:0]  cycle_d;
  logic [15:0]  fired_d;
  logic [15:0]  late_d;

  // push_ready depends only on the registered pointers, so a same-cycle pop
  // cannot reopen the slot until the following cycle.
  assign push_ready = !fifo_full;
  assign push_hs    = push_valid && push_ready && !abort;
  assign push_wr    = push_hs && (push_index != VERINJECT_IDLE_STATE);
  assign push_entry = '{cycle: push_cycle, index: push_index};

  // Head is due when its target cycle has been reached; strictly past means late.
  assign fire      = (state_q == ST_RUNNING) && !fifo_empty && !abort &&
                     (head.cycle <= cycle_q);
  assign fire_late = fire && (head.cycle < cycle_q);

  assign cycle_d = sat_inc32(cycle_q);
  assign fired_d = sat_inc16(fired_q);
  assign late_d  = fire_late ? sat_inc16(late_q) : late_q;

  verinject_sched_fifo #(
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_wr),
    .push_data (push_entry),
    .pop       (fire),
    .flush     (abort),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Scheduler FSM with registered bus, cycle counter and statistics.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cycle_q <= '0;
      inj_q   <= VERINJECT_IDLE_STATE;
      fired_q <= '0;
      late_q  <= '0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      cycle_q <= '0;
      inj_q   <= VERINJECT_IDLE_STATE;
      fired_q <= '0;
      late_q  <= '0;
    end else begin
      inj_q <= VERINJECT_IDLE_STATE;
      case (state_q)
        ST_IDLE: begin
          cycle_q <= '0;
          if (start) begin
            state_q <= ST_RUNNING;
            fired_q <= '0;
            late_q  <= '0;
          end
        end
        ST_RUNNING: begin
          cycle_q <= cycle_d;
          if (fire) begin
            inj_q   <= head.index;
            fired_q <= fired_d;
            late_q  <= late_d;
          end
          if (fifo_empty) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q <= ST_IDLE;
            cycle_q <= '0;
          end else if (push_wr) begin
            state_q <= ST_RUNNING;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cycle_q <= '0;
        end
      endcase
    end
  end

  assign verinject__injector_state = inj_q;
  assign cycle_count               = cycle_q;
  assign busy                      = (state_q == ST_RUNNING);
  assign done                      = (state_q == ST_DONE);
  assign fired_count               = fired_q;
  assign late_count                = late_q;

endmodule
